multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = memory states stall on mem_ready; 0 = mem_ready ignored, every memory state takes 1 cycle.
REQ-002 SHALL have parameter SEG_DIGITS, default 5, legal 4..8, meaning: number of active-low 7-segment mnemonic digits.
REQ-003 SHALL have parameter CNT_W, default 16, meaning: width of the retired-fetch counter.
REQ-004 SHALL have ports, one clock, reset synchronous active-high:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous active-high reset
 opcode  in  6  instruction[31:26] from the instruction register
 mem_ready  in  1  memory access complete this cycle
 pc_write, pc_write_cond, bne, i_or_d, ir_write, mem_read, mem_write  out  1 each  datapath enables
 mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath selects/enables
 alu_src_b, alu_op, pc_source  out  2 each  datapath selects
 state  out  4  current state encoding
 illegal_op  out  1  one-cycle pulse on unsupported opcode
 seg  out  7*SEG_DIGITS  digit i at bits [7i+6:7i], digit 0 leftmost
 fetch_count  out  CNT_W  completed instruction fetches

Function
REQ-005 SHALL implement a Moore FSM, encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BRANCH=8, JUMP=9, IEX=10, IWB=11; codes 12..15 SHALL go to FETCH next cycle with all enables 0.
REQ-006 SHALL latch opcode into op_q on the DECODE cycle; all later states use op_q only.
REQ-007 Transitions: FETCH->DECODE on completion; DECODE-> MEMADR (100011,101011), REX (000000), BRANCH (000100,000101), JUMP (000010), IEX (001000,001100), else FETCH with illegal_op=1 that cycle.
REQ-008 Transitions: MEMADR->MEMRD (lw) / MEMWR (sw); MEMRD->MEMWB on completion; MEMWR, MEMWB, RWB, IWB, BRANCH, JUMP->FETCH; REX->RWB; IEX->IWB.
REQ-009 "Completion" in FETCH/MEMRD/MEMWR SHALL be mem_ready=1 when MEM_WAIT=1, always when MEM_WAIT=0; otherwise state holds.
REQ-010 Unlisted outputs per state SHALL be 0:
 FETCH: mem_read=1, alu_src_b=01; ir_write=1, pc_write=1 only in completing cycle.
 DECODE: alu_src_b=11.
 MEMADR: alu_src_a=1, alu_src_b=10.
 MEMRD: mem_read=1, i_or_d=1 (held while stalled).
 MEMWB: mem_to_reg=1, reg_write=1.
 MEMWR: mem_write=1, i_or_d=1 (held while stalled).
 REX: alu_src_a=1, alu_op=10.  RWB: reg_dst=1, reg_write=1.
 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, bne=(op_q==000101).
 JUMP: pc_write=1, pc_source=10.
 IEX: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) / 11 (andi).  IWB: reg_write=1.
REQ-011 seg SHALL update on the DECODE cycle edge from opcode and hold until next DECODE; glyphs (active-low): A=0001000 d=1000010 i=0110000 n=0101011 L=1000111 w=1001001 S=0100100 b=1100000 e=0110000 q=0011000 J=1001111 r=0101111 E=0000110 blank=1111111.
REQ-012 Mnemonics, digits 0..: addi "Addi", andi "Andi", lw "Lw", sw "Sw", beq "beq", bne "bne", j "J", R-type "r", illegal "E"; remaining digits blank.
REQ-013 fetch_count SHALL increment on each ir_write=1 cycle, wrapping 2^CNT_W-1 -> 0.
REQ-014 Latency (MEM_WAIT=0): lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3 cycles.

Reset
REQ-015 reset=1 at a clock edge SHALL set state=FETCH, op_q=0, fetch_count=0, all seg digits blank, from any state including mid-stall.
REQ-016 While reset=1 all enables (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal_op) SHALL be 0 irrespective of state.

Verification
REQ-017 MEM_WAIT=0, opcode=100011 after reset -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; seg digits 0,1 = 1000111,1001001.
REQ-018 MEM_WAIT=1, mem_ready low 3 cycles in FETCH -> state 0 for 4 cycles, mem_read=1 throughout, ir_write=1 only on 4th; fetch_count 0->1.
REQ-019 opcode=000101 -> BRANCH with pc_write_cond=1, bne=1, pc_source=01, alu_op=01; opcode=000100 -> bne=0.
REQ-020 opcode=111111 -> illegal_op=1 in DECODE, next state 0, seg digit0=0000110, others 1111111.
REQ-021 reset asserted during MEMWR stall -> next cycle state=0, mem_write=0, fetch_count=0, seg blank.
REQ-022 CNT_W=2, five fetches -> fetch_count 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: state register, datapath control decode,
// 7-segment mnemonic of the last decoded opcode, and a retired-fetch counter.
module multicycle_control #(
  parameter int MEM_WAIT   = 1,
  parameter int SEG_DIGITS = 5,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    bne,
  output logic                    i_or_d,
  output logic                    ir_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic [3:0]              state,
  output logic                    illegal_op,
  output logic [7*SEG_DIGITS-1:0] seg,
  output logic [CNT_W-1:0]        fetch_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REX    = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  IEX    = 4'd10, IWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [6:0] G_A = 7'b0001000, G_D = 7'b1000010, G_I = 7'b0110000;
  localparam logic [6:0] G_N = 7'b0101011, G_L = 7'b1000111, G_W = 7'b1001001;
  localparam logic [6:0] G_S = 7'b0100100, G_B = 7'b1100000, G_E = 7'b0110000;
  localparam logic [6:0] G_Q = 7'b0011000, G_J = 7'b1001111, G_R = 7'b0101111;
  localparam logic [6:0] G_EE = 7'b0000110, G_BL = 7'b1111111;

  // Glyphs are listed rightmost-first so digit 0 (leftmost) lands in bits [6:0].
  function automatic logic [7*SEG_DIGITS-1:0] mnemonic(input logic [5:0] opc);
    logic [7*SEG_DIGITS-1:0] s;
    logic [27:0]             g;
    s = '1;
    case (opc)
      OP_ADDI:        g = {G_I,  G_D,  G_D,  G_A};
      OP_ANDI:        g = {G_I,  G_D,  G_N,  G_A};
      OP_LW:          g = {G_BL, G_BL, G_W,  G_L};
      OP_SW:          g = {G_BL, G_BL, G_W,  G_S};
      OP_BEQ:         g = {G_BL, G_Q,  G_E,  G_B};
      OP_BNE:         g = {G_BL, G_E,  G_N,  G_B};
      OP_J:           g = {G_BL, G_BL, G_BL, G_J};
      OP_RTYPE:       g = {G_BL, G_BL, G_BL, G_R};
      default:        g = {G_BL, G_BL, G_BL, G_EE};
    endcase
    for (int unsigned i = 0; i < 4; i++) s[7*i +: 7] = g[7*i +: 7];
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [5:0]              op_q, op_d;
  logic [7*SEG_DIGITS-1:0] seg_q, seg_d;
  logic [CNT_W-1:0]        fetch_count_q, fetch_count_d;
  logic                    mem_done;

  assign mem_done = (MEM_WAIT == 0) || mem_ready;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    seg_d         = seg_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bne           = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode;
        seg_d     = mnemonic(opcode);
        case (opcode)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYPE:         state_d = REX;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_ADDI, OP_ANDI: state_d = IEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_done) state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_done) state_d = FETCH;
      end
      REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RWB;
      end
      RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        bne           = (op_q == OP_BNE);
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
        state_d   = IWB;
      end
      IWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Enables are forced low for the whole reset cycle, whatever the state.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end

    fetch_count_d = fetch_count_q + CNT_W'(ir_write);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      op_q          <= '0;
      seg_q         <= '1;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      seg_q         <= seg_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign state       = state_q;
  assign seg         = seg_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a stalling instance (MEM_WAIT=1) and a
// no-wait, 2-bit-counter instance (MEM_WAIT=0, CNT_W=2) share one stimulus.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mem_ready;
  logic [5:0] opcode;

  logic pc_write_w, pc_write_cond_w, bne_w, i_or_d_w, ir_write_w, mem_read_w, mem_write_w;
  logic mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, illegal_op_w;
  logic [1:0] alu_src_b_w, alu_op_w, pc_source_w;
  logic [3:0] state_w;
  logic [34:0] seg_w;
  logic [15:0] fetch_count_w;

  logic pc_write_n, pc_write_cond_n, bne_n, i_or_d_n, ir_write_n, mem_read_n, mem_write_n;
  logic mem_to_reg_n, reg_dst_n, reg_write_n, alu_src_a_n, illegal_op_n;
  logic [1:0] alu_src_b_n, alu_op_n, pc_source_n;
  logic [3:0] state_n;
  logic [34:0] seg_n;
  logic [1:0] fetch_count_n;

  multicycle_control #(.MEM_WAIT(1), .SEG_DIGITS(5), .CNT_W(16)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_w), .pc_write_cond(pc_write_cond_w), .bne(bne_w), .i_or_d(i_or_d_w),
    .ir_write(ir_write_w), .mem_read(mem_read_w), .mem_write(mem_write_w),
    .mem_to_reg(mem_to_reg_w), .reg_dst(reg_dst_w), .reg_write(reg_write_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w),
    .pc_source(pc_source_w), .state(state_w), .illegal_op(illegal_op_w),
    .seg(seg_w), .fetch_count(fetch_count_w));

  multicycle_control #(.MEM_WAIT(0), .SEG_DIGITS(5), .CNT_W(2)) dut_n (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .pc_write_cond(pc_write_cond_n), .bne(bne_n), .i_or_d(i_or_d_n),
    .ir_write(ir_write_n), .mem_read(mem_read_n), .mem_write(mem_write_n),
    .mem_to_reg(mem_to_reg_n), .reg_dst(reg_dst_n), .reg_write(reg_write_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_op(alu_op_n),
    .pc_source(pc_source_n), .state(state_n), .illegal_op(illegal_op_n),
    .seg(seg_n), .fetch_count(fetch_count_n));

  logic [21:0] ctrl_w, ctrl_n;
  assign ctrl_w = {pc_write_w, pc_write_cond_w, bne_w, i_or_d_w, ir_write_w, mem_read_w,
                   mem_write_w, mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w,
                   alu_src_b_w, alu_op_w, pc_source_w, state_w, illegal_op_w};
  assign ctrl_n = {pc_write_n, pc_write_cond_n, bne_n, i_or_d_n, ir_write_n, mem_read_n,
                   mem_write_n, mem_to_reg_n, reg_dst_n, reg_write_n, alu_src_a_n,
                   alu_src_b_n, alu_op_n, pc_source_n, state_n, illegal_op_n};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "A":      return 7'b0001000;
      "d":      return 7'b1000010;
      "i", "e": return 7'b0110000;
      "n":      return 7'b0101011;
      "L":      return 7'b1000111;
      "w":      return 7'b1001001;
      "S":      return 7'b0100100;
      "b":      return 7'b1100000;
      "q":      return 7'b0011000;
      "J":      return 7'b1001111;
      "r":      return 7'b0101111;
      "E":      return 7'b0000110;
      default:  return 7'b1111111;
    endcase
  endfunction

  function automatic string name_of(input logic [5:0] opc);
    case (opc)
      6'h23: return "Lw";
      6'h2B: return "Sw";
      6'h00: return "r";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h02: return "J";
      6'h08: return "Addi";
      6'h0C: return "Andi";
      default: return "E";
    endcase
  endfunction

  function automatic logic [34:0] seg_of(input string s);
    logic [34:0] r;
    r = '1;
    for (int i = 0; i < s.len(); i++) r[7*i +: 7] = glyph(s[i]);
    return r;
  endfunction

  function automatic logic [21:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic [5:0] opc, input bit mr,
                                           input bit rst, input bit mw);
    bit pcw = 0, pwc = 0, bn = 0, iod = 0, irw = 0, mrd = 0, mwr = 0;
    bit m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    bit done;
    done = mw ? mr : 1'b1;
    case (st)
      0: begin mrd = 1; asb = 1; if (done) begin irw = 1; pcw = 1; end end
      1: begin asb = 3; ill = (name_of(opc) == "E"); end
      2: begin asa = 1; asb = 2; end
      3: begin mrd = 1; iod = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin asa = 1; aop = 2; end
      7: begin rdst = 1; rw = 1; end
      8: begin asa = 1; aop = 1; pwc = 1; psrc = 1; bn = (op == 6'h05); end
      9: begin pcw = 1; psrc = 2; end
      10: begin asa = 1; asb = 2; aop = (op == 6'h0C) ? 2'd3 : 2'd0; end
      11: rw = 1;
      default: ;
    endcase
    if (rst) begin pcw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; ill = 0; end
    return {pcw, pwc, bn, iod, irw, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, 4'(st), ill};
  endfunction

  // Model per instance (0 = stalling, 1 = no-wait): the instruction's remaining
  // state walk is queued at decode and consumed one state per completed step.
  int          cur[2];
  logic [5:0]  mop[2];
  logic [34:0] mseg[2];
  int          mcnt[2];
  int          path[2][$];
  bit          mvalid = 0;

  task automatic advance(input int m);
    if (path[m].size() > 0) cur[m] = path[m].pop_front();
    else cur[m] = 0;
  endtask

  task automatic step(input int m, input bit rst, input logic [5:0] opc, input bit mr);
    bit done;
    done = (m == 0) ? mr : 1'b1;
    if (rst) begin
      cur[m] = 0; mop[m] = 0; mseg[m] = '1; mcnt[m] = 0; path[m].delete();
      return;
    end
    case (cur[m])
      0: if (done) begin mcnt[m] = (mcnt[m] + 1) % ((m == 0) ? 65536 : 4); cur[m] = 1; end
      1: begin
        mop[m]  = opc;
        mseg[m] = seg_of(name_of(opc));
        case (opc)
          6'h23:        path[m] = {2, 3, 4};
          6'h2B:        path[m] = {2, 5};
          6'h00:        path[m] = {6, 7};
          6'h04, 6'h05: path[m] = {8};
          6'h02:        path[m] = {9};
          6'h08, 6'h0C: path[m] = {10, 11};
          default:      path[m].delete();
        endcase
        advance(m);
      end
      3, 5: if (done) advance(m);
      default: advance(m);
    endcase
  endtask

  // ---------------- drive / compare ----------------
  bit cur_rst, cur_mr;

  task automatic apply(input bit rst, input logic [5:0] opc, input bit mr);
    reset = rst; opcode = opc; mem_ready = mr; cur_rst = rst; cur_mr = mr;
    #1;
    if (mvalid) begin
      chk("w.ctrl", ctrl_w, exp_ctrl(cur[0], mop[0], opc, mr, rst, 1'b1));
      chk("n.ctrl", ctrl_n, exp_ctrl(cur[1], mop[1], opc, mr, rst, 1'b0));
      chk("w.seg", seg_w, mseg[0]);
      chk("n.seg", seg_n, mseg[1]);
      chk("w.fetch_count", fetch_count_w, mcnt[0]);
      chk("n.fetch_count", fetch_count_n, mcnt[1]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step(0, cur_rst, opcode, cur_mr);
    step(1, cur_rst, opcode, cur_mr);
    if (cur_rst) mvalid = 1;
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    logic [5:0] opc;
    bit         mr;
    int         st_w;
    int         st_n;
    bit         irw_w;
    bit         irw_n;
    int         cnt_n;
  } vec_t;

  vec_t tbl[15];
  logic [5:0] legal_ops[9] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h3F};

  initial begin
    // lw with 3-cycle fetch stall on the waiting instance; no-wait instance
    // runs lw then sw; both then fetch bne and wrap the 2-bit counter.
    tbl[0]  = '{1, 6'h00, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 6'h23, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 6'h23, 0, 0, 1, 0, 0, 1};
    tbl[3]  = '{0, 6'h23, 0, 0, 2, 0, 0, 1};
    tbl[4]  = '{0, 6'h23, 1, 0, 3, 1, 0, 1};
    tbl[5]  = '{0, 6'h23, 0, 1, 4, 0, 0, 1};
    tbl[6]  = '{0, 6'h2B, 0, 2, 0, 0, 1, 1};
    tbl[7]  = '{0, 6'h2B, 0, 3, 1, 0, 0, 2};
    tbl[8]  = '{0, 6'h2B, 1, 3, 2, 0, 0, 2};
    tbl[9]  = '{0, 6'h2B, 0, 4, 5, 0, 0, 2};
    tbl[10] = '{0, 6'h2B, 1, 0, 0, 1, 1, 2};
    tbl[11] = '{0, 6'h05, 0, 1, 1, 0, 0, 3};
    tbl[12] = '{0, 6'h05, 0, 8, 8, 0, 0, 3};
    tbl[13] = '{0, 6'h00, 1, 0, 0, 1, 1, 3};
    tbl[14] = '{0, 6'h00, 1, 1, 1, 0, 0, 0};

    @(negedge clk);
    apply(1, 6'h00, 0);
    tick();

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rst, tbl[i].opc, tbl[i].mr);
      chk($sformatf("tbl[%0d].state_w", i), state_w, tbl[i].st_w);
      chk($sformatf("tbl[%0d].state_n", i), state_n, tbl[i].st_n);
      chk($sformatf("tbl[%0d].ir_write_w", i), ir_write_w, tbl[i].irw_w);
      chk($sformatf("tbl[%0d].ir_write_n", i), ir_write_n, tbl[i].irw_n);
      chk($sformatf("tbl[%0d].fetch_count_n", i), fetch_count_n, tbl[i].cnt_n);
      if (i == 3) chk("lw_seg_n", seg_n[13:0], {7'b1001001, 7'b1000111});
      if (i >= 1 && i <= 4) chk($sformatf("tbl[%0d].mem_read_w", i), mem_read_w, 1);
      tick();
    end

    // bne / beq branch controls
    apply(1, 6'h05, 1); tick();
    apply(0, 6'h05, 1); tick();
    apply(0, 6'h05, 1); tick();
    apply(0, 6'h00, 1);
    chk("bne.state", state_w, 8);
    chk("bne.bne", bne_w, 1);
    chk("bne.pc_write_cond", pc_write_cond_w, 1);
    chk("bne.pc_source", pc_source_w, 2'b01);
    chk("bne.alu_op", alu_op_w, 2'b01);
    tick();
    apply(0, 6'h04, 1); tick();
    apply(0, 6'h04, 1); tick();
    apply(0, 6'h00, 1);
    chk("beq.state", state_w, 8);
    chk("beq.bne", bne_w, 0);
    tick();

    // illegal opcode
    apply(0, 6'h3F, 1); tick();
    apply(0, 6'h3F, 1);
    chk("ill.state", state_w, 1);
    chk("ill.illegal_op_w", illegal_op_w, 1);
    chk("ill.illegal_op_n", illegal_op_n, 1);
    tick();
    apply(0, 6'h00, 0);
    chk("ill.next_state", state_w, 0);
    chk("ill.seg", seg_w, {{4{7'b1111111}}, 7'b0000110});
    tick();

    // reset in the middle of a MEMWR stall
    apply(0, 6'h2B, 1); tick();
    apply(0, 6'h2B, 0); tick();
    apply(0, 6'h2B, 0); tick();
    apply(0, 6'h2B, 0);
    chk("swstall.state", state_w, 5);
    chk("swstall.mem_write", mem_write_w, 1);
    tick();
    apply(1, 6'h2B, 0);
    chk("swrst.mem_write_in_reset", mem_write_w, 0);
    tick();
    apply(0, 6'h00, 0);
    chk("swrst.state", state_w, 0);
    chk("swrst.mem_write", mem_write_w, 0);
    chk("swrst.fetch_count", fetch_count_w, 0);
    chk("swrst.seg", seg_w, {35{1'b1}});
    tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 3) == 0) opc = 6'($urandom);
      else opc = legal_ops[$urandom_range(0, 8)];
      apply($urandom_range(0, 39) == 0, opc, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
